// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR unit.
//   CSR addresses, csr_op encoding, interrupt cause codes, mstatus/mie/mip
//   bit positions and the fixed read-only values (mstatus reset, MPP, misa).
package csr_pkg;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIX_MSI_BIT      = 3;
  localparam int MIX_MTI_BIT      = 7;
  localparam int MIX_MEI_BIT      = 11;

  localparam logic [31:0] MSTATUS_RESET  = 32'h0000_1880;
  localparam logic [31:0] MSTATUS_MPP_RO = 32'h0000_1800;
  localparam logic [31:0] MISA_VALUE     = 32'h4000_0100;

endpackage

// File: rtl/csr_unit_m_counter64.sv
// csr_counter64: 64-bit event counter with 32-bit half write ports.
//   clk, reset_x : falling-edge clock, synchronous active-low reset
//   inc          : count enable
//   wr_lo, wr_hi : replace the low / high half with wdata
//   count        : current 64-bit value
// Any half write suppresses the increment on that edge, so a written
// value is never bumped by the count that happens alongside it.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) cnt_d[31:0]  = wdata;
      if (wr_hi) cnt_d[63:32] = wdata;
    end else if (inc) begin
      cnt_d = cnt_q + 64'd1;  // carry into hi on the same edge as lo wrap
    end
  end

  always_ff @(negedge clk) begin
    if (!reset_x) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/csr_unit_m.sv
// csr_unit_m: machine-mode CSR unit (mstatus, misa, mie, mtvec, mscratch,
// mepc, mcause, mtval, mip, mhartid, optional cycle/instret counters).
//   clk/reset_x        : state updates on falling edge; sync active-low reset
//   csr_addr/op/wdata  : CSR access from decode; csr_rdata/csr_illegal comb.
//   exc_*              : synchronous exception capture
//   irq_ext/timer/soft : level interrupt lines; irq_req/irq_ack handshake
//   mret, retire       : trap return, instruction retired
//   trap_vector        : redirect target; mepc_out : mepc contents
// Build option: CSR_COUNTERS_EN adds mcycle/minstret and their user views.
module csr_unit_m
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
  parameter int              HART_ID     = 0
) (
  input  logic            clk,
  input  logic            reset_x,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  output logic            irq_req,
  input  logic            irq_ack,
  input  logic            mret,
  input  logic            retire,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mepc_out
);

  // mie_en/mip vectors are {MEI, MTI, MSI}
  logic            st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic [2:0]      mie_en_q, mie_en_d, mip_q, mip_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic            irq_req_q, irq_req_d;

  csr_op_e         op;
  logic [XLEN-1:0] old_val, new_val, base;
  logic            impl, ro, wr_op, illegal, csr_we, ack_take, do_mret;
  logic [2:0]      pending;
  logic [3:0]      irq_code;

  assign op = csr_op_e'(csr_op);
  // RS/RC with zero mask are pure reads and never count as writes
  assign wr_op = (op == CSR_RW) || ((op != CSR_NONE) && (csr_wdata != '0));

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
  csr_counter64 u_mcycle (
    .clk(clk), .reset_x(reset_x), .inc(1'b1),
    .wr_lo(csr_we && csr_addr == ADDR_MCYCLE),
    .wr_hi(csr_we && csr_addr == ADDR_MCYCLEH),
    .wdata(csr_wdata[31:0]), .count(mcycle)
  );
  csr_counter64 u_minstret (
    .clk(clk), .reset_x(reset_x), .inc(retire),
    .wr_lo(csr_we && csr_addr == ADDR_MINSTRET),
    .wr_hi(csr_we && csr_addr == ADDR_MINSTRETH),
    .wdata(csr_wdata[31:0]), .count(minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  // read mux
  always_comb begin
    impl    = 1'b1;
    ro      = 1'b0;
    old_val = '0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        old_val                   = XLEN'(MSTATUS_MPP_RO);
        old_val[MSTATUS_MIE_BIT]  = st_mie_q;
        old_val[MSTATUS_MPIE_BIT] = st_mpie_q;
      end
      ADDR_MISA: begin old_val = XLEN'(MISA_VALUE); ro = 1'b1; end
      ADDR_MIE: begin
        old_val[MIX_MEI_BIT] = mie_en_q[2];
        old_val[MIX_MTI_BIT] = mie_en_q[1];
        old_val[MIX_MSI_BIT] = mie_en_q[0];
      end
      ADDR_MTVEC:    old_val = mtvec_q;
      ADDR_MSCRATCH: old_val = mscratch_q;
      ADDR_MEPC:     old_val = mepc_q;
      ADDR_MCAUSE:   old_val = mcause_q;
      ADDR_MTVAL:    old_val = mtval_q;
      ADDR_MIP: begin
        old_val[MIX_MEI_BIT] = mip_q[2];
        old_val[MIX_MTI_BIT] = mip_q[1];
        old_val[MIX_MSI_BIT] = mip_q[0];
      end
      ADDR_MHARTID:  old_val = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE,   ADDR_CYCLE:    old_val = XLEN'(mcycle[31:0]);
      ADDR_MCYCLEH,  ADDR_CYCLEH:   old_val = XLEN'(mcycle[63:32]);
      ADDR_MINSTRET, ADDR_INSTRET:  old_val = XLEN'(minstret[31:0]);
      ADDR_MINSTRETH, ADDR_INSTRETH: old_val = XLEN'(minstret[63:32]);
`endif
      default: impl = 1'b0;
    endcase
  end

  assign illegal = (op != CSR_NONE) &&
                   (!impl || ((ro || csr_addr[11:10] == 2'b11) && wr_op));
  assign csr_illegal = illegal;
  assign csr_rdata   = illegal ? '0 : old_val;

  always_comb begin
    case (op)
      CSR_RS:  new_val = old_val | csr_wdata;
      CSR_RC:  new_val = old_val & ~csr_wdata;
      default: new_val = csr_wdata;
    endcase
  end

  // interrupt arbitration: MEI > MSI > MTI
  assign pending = mip_q & mie_en_q;
  always_comb begin
    if (pending[2])      irq_code = IRQ_CODE_MEI;
    else if (pending[0]) irq_code = IRQ_CODE_MSI;
    else                 irq_code = IRQ_CODE_MTI;
  end

  assign ack_take = !exc_valid && irq_ack && irq_req_q && (|pending);
  assign do_mret  = !exc_valid && !ack_take && mret;
  assign csr_we   = !exc_valid && !ack_take && !mret && wr_op && !illegal;

  assign base        = mtvec_q & ~XLEN'(3);
  assign trap_vector = (ack_take && mtvec_q[1:0] == 2'b01) ?
                       base + XLEN'({irq_code, 2'b00}) : base;
  assign mepc_out    = mepc_q;
  assign irq_req     = irq_req_q;

  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_en_d   = mie_en_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mip_d      = {irq_ext, irq_timer, irq_soft};
    if (exc_valid) begin
      mepc_d    = exc_pc & ~XLEN'(3);
      mcause_d  = XLEN'(exc_cause);
      mtval_d   = exc_tval;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else if (ack_take) begin
      mepc_d    = exc_pc & ~XLEN'(3);
      mcause_d  = {1'b1, {(XLEN-5){1'b0}}, irq_code};
      mtval_d   = '0;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else if (do_mret) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          st_mie_d  = new_val[MSTATUS_MIE_BIT];
          st_mpie_d = new_val[MSTATUS_MPIE_BIT];
        end
        ADDR_MIE:      mie_en_d = {new_val[MIX_MEI_BIT], new_val[MIX_MTI_BIT],
                                   new_val[MIX_MSI_BIT]};
        // mode 1x is reserved and collapses to direct
        ADDR_MTVEC:    mtvec_d = new_val[1] ? (new_val & ~XLEN'(3)) : new_val;
        ADDR_MSCRATCH: mscratch_d = new_val;
        ADDR_MEPC:     mepc_d = new_val & ~XLEN'(3);
        ADDR_MCAUSE:   mcause_d = new_val;
        ADDR_MTVAL:    mtval_d = new_val;
        default: ;
      endcase
    end
    // uses the pre-edge mip sample so a line takes two edges to reach irq_req,
    // but next-state enables so taking a trap drops the request immediately
    irq_req_d = st_mie_d && |(mip_q & mie_en_d);
  end

  always_ff @(negedge clk) begin
    if (!reset_x) begin
      st_mie_q   <= MSTATUS_RESET[MSTATUS_MIE_BIT];
      st_mpie_q  <= MSTATUS_RESET[MSTATUS_MPIE_BIT];
      mie_en_q   <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
      irq_req_q  <= 1'b0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_en_q   <= mie_en_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mip_q      <= mip_d;
      irq_req_q  <= irq_req_d;
    end
  end

endmodule

// File: tb/tb_csr_unit_m.sv
// Directed bench for csr_unit_m. State changes on the falling edge, so all
// driving and sampling happens 1 time unit after each falling edge.
module tb_csr_unit_m;

  logic        clk = 1'b0;
  logic        reset_x;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata, csr_rdata, exc_pc, exc_tval, trap_vector, mepc_out;
  logic        csr_illegal, exc_valid, irq_ext, irq_timer, irq_soft;
  logic        irq_req, irq_ack, mret, retire;
  logic [3:0]  exc_cause;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  csr_unit_m #(.XLEN(32), .MTVEC_RESET(32'h0000_0100), .HART_ID(5)) dut (
    .clk(clk), .reset_x(reset_x), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .irq_soft(irq_soft), .irq_req(irq_req), .irq_ack(irq_ack), .mret(mret),
    .retire(retire), .trap_vector(trap_vector), .mepc_out(mepc_out)
  );

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic drive(input logic [11:0] a, input logic [1:0] o, input logic [31:0] w);
    csr_addr = a; csr_op = o; csr_wdata = w; #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] o, input logic [31:0] w);
    drive(a, o, w); tick(); drive(a, 2'b00, 32'h0);
  endtask

  task automatic test_reset();
    drive(12'h300, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL rst_mstatus got %h want 00001880", csr_rdata); end
    drive(12'h305, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h100) begin errors++; $display("FAIL rst_mtvec got %h want 00000100", csr_rdata); end
    drive(12'hF14, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h5) begin errors++; $display("FAIL rst_mhartid got %h want 00000005", csr_rdata); end
    checks++;
    if (irq_req !== 1'b0 || mepc_out !== 32'h0) begin errors++; $display("FAIL rst_irq_mepc got %b/%h want 0/0", irq_req, mepc_out); end
    drive(12'h301, 2'b01, 32'h123); checks++;
    if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin errors++; $display("FAIL misa_wr_illegal got %b/%h want 1/0", csr_illegal, csr_rdata); end
    tick(); drive(12'h301, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h4000_0100) begin errors++; $display("FAIL misa_val got %h want 40000100", csr_rdata); end
    drive(12'hF14, 2'b10, 32'h0); checks++;
    if (csr_illegal !== 1'b0 || csr_rdata !== 32'h5) begin errors++; $display("FAIL hartid_rs0 got %b/%h want 0/5", csr_illegal, csr_rdata); end
    drive(12'h7C0, 2'b10, 32'h1); checks++;
    if (csr_illegal !== 1'b1) begin errors++; $display("FAIL unimpl_illegal got %b want 1", csr_illegal); end
    drive(12'h7C0, 2'b00, 0);
  endtask

  task automatic test_warl();
    drive(12'h300, 2'b01, 32'hFFFF_FFFF); checks++;
    if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL rw_old got %h want 00001880", csr_rdata); end
    tick(); drive(12'h300, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL mstatus_rw got %h want 00001888", csr_rdata); end
    wr(12'h300, 2'b11, 32'h8); checks++;
    if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL mstatus_rc got %h want 00001880", csr_rdata); end
    drive(12'h300, 2'b10, 32'h0); checks++;
    if (csr_rdata !== 32'h1880 || csr_illegal !== 1'b0) begin errors++; $display("FAIL rs0_read got %h/%b want 00001880/0", csr_rdata, csr_illegal); end
    tick(); drive(12'h300, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL rs0_nowrite got %h want 00001880", csr_rdata); end
    wr(12'h304, 2'b01, 32'hFFFF_FFFF); checks++;
    if (csr_rdata !== 32'h888) begin errors++; $display("FAIL mie_mask got %h want 00000888", csr_rdata); end
    wr(12'h305, 2'b01, 32'h2003); checks++;
    if (csr_rdata !== 32'h2000) begin errors++; $display("FAIL mtvec_mode got %h want 00002000", csr_rdata); end
    wr(12'h341, 2'b01, 32'h123); checks++;
    if (mepc_out !== 32'h120) begin errors++; $display("FAIL mepc_align got %h want 00000120", mepc_out); end
    drive(12'h344, 2'b01, 32'hFFFF); checks++;
    if (csr_illegal !== 1'b0) begin errors++; $display("FAIL mip_wr_legal got %b want 0", csr_illegal); end
    tick(); drive(12'h344, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mip_ro got %h want 0", csr_rdata); end
  endtask

  task automatic test_irq();
    wr(12'h305, 2'b01, 32'h1001);
    wr(12'h304, 2'b01, 32'h800);
    wr(12'h300, 2'b10, 32'h8);
    irq_ext = 1'b1; tick(); checks++;
    if (irq_req !== 1'b0) begin errors++; $display("FAIL irq_lat1 got %b want 0", irq_req); end
    tick(); checks++;
    if (irq_req !== 1'b1) begin errors++; $display("FAIL irq_lat2 got %b want 1", irq_req); end
    irq_ack = 1'b1; exc_pc = 32'h104; #1; checks++;
    if (trap_vector !== 32'h102C) begin errors++; $display("FAIL irq_vector got %h want 0000102c", trap_vector); end
    tick(); irq_ack = 1'b0; drive(12'h342, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h8000_000B) begin errors++; $display("FAIL irq_mcause got %h want 8000000b", csr_rdata); end
    checks++;
    if (mepc_out !== 32'h104) begin errors++; $display("FAIL irq_mepc got %h want 00000104", mepc_out); end
    drive(12'h300, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h1880 || irq_req !== 1'b0) begin errors++; $display("FAIL irq_mstatus got %h/%b want 00001880/0", csr_rdata, irq_req); end
  endtask

  task automatic test_exc_priority();
    irq_ext = 1'b0; tick(); tick();
    wr(12'h300, 2'b10, 32'h8);
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h203; exc_tval = 32'hDEAD;
    irq_ack = 1'b1; mret = 1'b1; drive(12'h340, 2'b01, 32'h77); checks++;
    if (trap_vector !== 32'h1000) begin errors++; $display("FAIL exc_vector got %h want 00001000", trap_vector); end
    tick(); exc_valid = 1'b0; irq_ack = 1'b0; mret = 1'b0;
    drive(12'h342, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h2) begin errors++; $display("FAIL exc_mcause got %h want 00000002", csr_rdata); end
    checks++;
    if (mepc_out !== 32'h200) begin errors++; $display("FAIL exc_mepc got %h want 00000200", mepc_out); end
    drive(12'h343, 2'b00, 0); checks++;
    if (csr_rdata !== 32'hDEAD) begin errors++; $display("FAIL exc_mtval got %h want 0000dead", csr_rdata); end
    drive(12'h340, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h0) begin errors++; $display("FAIL exc_blocks_wr got %h want 0", csr_rdata); end
    drive(12'h300, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL exc_mstatus got %h want 00001880", csr_rdata); end
    mret = 1'b1; tick(); mret = 1'b0; #1; checks++;
    if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got %h want 00001888", csr_rdata); end
    irq_ack = 1'b1; exc_pc = 32'h500; tick(); irq_ack = 1'b0;
    drive(12'h342, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h2 || mepc_out !== 32'h200) begin errors++; $display("FAIL stray_ack got %h/%h want 2/200", csr_rdata, mepc_out); end
  endtask

  task automatic test_reset_mid_trap();
    reset_x = 1'b0; exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h300;
    tick(); reset_x = 1'b1; exc_valid = 1'b0;
    drive(12'h342, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h0 || mepc_out !== 32'h0) begin errors++; $display("FAIL rst_trap got %h/%h want 0/0", csr_rdata, mepc_out); end
    drive(12'h300, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL rst_trap_mstatus got %h want 00001880", csr_rdata); end
  endtask

`ifdef CSR_COUNTERS_EN
  task automatic test_counters();
    wr(12'hB00, 2'b01, 32'hFFFF_FFFE); tick(); tick();
    drive(12'hB80, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h1) begin errors++; $display("FAIL mcycleh_carry got %h want 1", csr_rdata); end
    drive(12'hB00, 2'b00, 0); checks++;
    if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mcycle_wrap got %h want 0", csr_rdata); end
    wr(12'hB00, 2'b01, 32'hFFFF_FFFE); tick();
    wr(12'hB80, 2'b01, 32'h55); checks++;
    if (csr_rdata !== 32'h55) begin errors++; $display("FAIL mcycleh_wr_wins got %h want 55", csr_rdata); end
    drive(12'hB00, 2'b00, 0); checks++;
    if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_inc_supp got %h want ffffffff", csr_rdata); end
    drive(12'hC00, 2'b01, 32'h1); checks++;
    if (csr_illegal !== 1'b1) begin errors++; $display("FAIL cycle_view_ro got %b want 1", csr_illegal); end
    drive(12'hC00, 2'b00, 0);
    retire = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) drive(12'hB02, 2'b01, 32'h100);
      tick(); drive(12'hB02, 2'b00, 0);
    end
    retire = 1'b0; #1; checks++;
    if (csr_rdata !== 32'h105) begin errors++; $display("FAIL minstret got %h want 00000105", csr_rdata); end
  endtask
`else
  task automatic test_counters();
    drive(12'hB00, 2'b10, 32'h0); checks++;
    if (csr_illegal !== 1'b1) begin errors++; $display("FAIL no_cnt_b00 got %b want 1", csr_illegal); end
    drive(12'hC02, 2'b10, 32'h0); checks++;
    if (csr_illegal !== 1'b1) begin errors++; $display("FAIL no_cnt_c02 got %b want 1", csr_illegal); end
    drive(12'hC02, 2'b00, 0);
  endtask
`endif

  initial begin
    reset_x = 1'b0; csr_addr = 0; csr_op = 0; csr_wdata = 0;
    exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0;
    irq_ext = 0; irq_timer = 0; irq_soft = 0; irq_ack = 0; mret = 0; retire = 0;
    tick(); tick(); reset_x = 1'b1;
    test_reset();
    test_warl();
    test_irq();
    test_exc_priority();
    test_reset_mid_trap();
    test_counters();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
